pqr5_lsu: RTL and testbench
===========================

Name: pqr5_lsu

Overview:
- Load/store unit for the PQR5 core: the memory-side counterpart of the LOAD/STORE encodings (F3_LB..F3_SW, BYTE/HWORD/WORD).
- Accepts one decoded LOAD or STORE from execute, drives an aligned 32-bit data-memory request with byte enables, then returns extracted and sign/zero-extended load data to writeback.
- Sits between the execute stage and the data-memory port; one transaction outstanding at a time.

Parameters:
- RSIZE, 32, register/data width; taken from pqr5_core_pkg::RSIZE. Only 32 is supported.
- AW, 32, byte address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute presents a memory operation
- ex_ready  out  1  LSU can accept (high only in IDLE)
- ex_is_load  in  1  1 = load (OP_LOAD), 0 = store (OP_STORE)
- ex_funct3  in  3  funct3 of the instruction
- ex_addr  in  AW  effective byte address (rs1 + imm)
- ex_wdata  in  RSIZE  rs2 value (stores)
- ex_rd  in  5  destination register (loads)
- dm_req_valid  out  1  memory request valid
- dm_req_ready  in  1  memory accepts the request
- dm_addr  out  AW  word-aligned address: ex_addr with [1:0] forced to 0
- dm_we  out  1  write enable
- dm_be  out  4  byte enables
- dm_wdata  out  RSIZE  lane-replicated store data
- dm_rsp_valid  in  1  load data valid, one-cycle pulse
- dm_rdata  in  RSIZE  load data word
- wb_valid  out  1  load result or exception pending
- wb_ready  in  1  writeback accepts
- wb_rd  out  5  destination register
- wb_data  out  RSIZE  extended load data
- wb_exc  out  1  misaligned access or illegal funct3; wb_data = 0
- st_done  out  1  one-cycle pulse when a store is accepted by memory

Behaviour:
- Reset: state = IDLE. All outputs 0 except ex_ready = 1. Reset mid-transaction abandons it; no wb_valid and no st_done follow.
- Capture: ex_valid & ex_ready registers the operation.
- Access size:
  - funct3[1:0]: 00 BYTE, 01 HWORD, 10 WORD.
  - funct3[2] = 1 on a load means unsigned (LBU, LHU).
  - Illegal: store funct3 ∉ {000, 001, 010}; load funct3 ∉ {000, 001, 010, 100, 101}.
- Alignment:
  - HWORD requires addr[0] = 0; WORD requires addr[1:0] = 0.
  - A violation or illegal funct3 issues no memory request. The LSU goes directly to WB with wb_exc = 1 (loads and stores alike), wb_rd = captured rd.
- Byte enables:
  - BYTE: 4'b0001 << addr[1:0].
  - HWORD: addr[1] ? 4'b1100 : 4'b0011.
  - WORD: 4'b1111.
  - Stores and loads use the same be.
- Store data: BYTE replicates rs2[7:0] ×4; HWORD replicates rs2[15:0] ×2; WORD passes rs2.
- Load extraction:
  - Byte lane addr[1:0] for BYTE; half addr[1] for HWORD.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, LW is raw.
- FSM:
  - IDLE –capture, legal→ REQ.
  - IDLE –capture, illegal→ WB (exc).
  - REQ: dm_req_valid = 1. Request signals are stable until dm_req_ready.
    - On acceptance with store: pulse st_done, → IDLE.
    - On acceptance with load: → RSP.
  - RSP: wait for dm_rsp_valid; register extracted data → WB.
  - WB: wb_valid = 1 with stable outputs until wb_ready, then → IDLE.
- dm_rsp_valid outside RSP is ignored.
- Latency: store is 1 cycle after capture when memory is ready. Load gives wb_valid 1 cycle after dm_rsp_valid; minimum 3 cycles capture→wb_valid.
- No back-to-back bypass: ex_ready returns the cycle after the IDLE re-entry transition, i.e. one bubble per op.

Decomposition:
- Add to pqr5_core_pkg:
  - LSU state enum (IDLE, REQ, RSP, WB).
  - Functions f_lsu_be(size, addr_lo), f_lsu_st_align(size, data), f_lsu_ld_extend(funct3, addr_lo, word), f_lsu_misaligned(size, addr_lo).
  - Reuse BYTE/HWORD/WORD and F3_* from the package.
- No sub-module required. Optionally split out pqr5_lsu_ld_align (combinational load extractor) for unit testing.

Test Plan:
- SB addr 0x1003, rs2 0x000000A5, dm_req_ready = 1 → dm_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5, we = 1, st_done pulse, no wb_valid.
- LH addr 0x2002, rdata 0x8001_1234 → be 4'b1100, wb_data 0xFFFF8001; same with LHU → 0x00008001.
- LB addr 0x11, rdata 0x0000_7F00 → wb_data 0x0000007F; rsp delayed 5 cycles → wb_valid exactly 1 cycle after the rsp pulse.
- LW addr 0x06 → no dm_req_valid, wb_valid with wb_exc = 1, wb_data 0; SH addr 0x01 → wb_exc = 1.
- dm_req_ready held low 4 cycles then high, and wb_ready low 3 cycles → request and wb outputs stable throughout, ex_ready = 0 until IDLE.
- rst asserted while in RSP → next cycle all outputs 0, ex_ready = 1; a late dm_rsp_valid produces no wb_valid.

Source files
------------

// File: rtl/pqr5_core_pkg.sv
// rtl/pqr5_core_pkg.sv - shared PQR5 core types, constants and LSU helper functions
//
// Purpose: access-size and funct3 encodings for LOAD/STORE, the LSU state
// enum, and the pure functions the LSU uses for byte enables, store lane
// replication, load extraction and legality checks.
// Ports: none (package).

package pqr5_core_pkg;

   localparam int RSIZE = 32;

   // Access size, funct3[1:0]
   localparam logic [1:0] BYTE  = 2'b00;
   localparam logic [1:0] HWORD = 2'b01;
   localparam logic [1:0] WORD  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RSP  = 2'd2,
      LSU_WB   = 2'd3
   } lsu_state_e;

   function automatic logic [3:0] f_lsu_be(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         BYTE:    be = 4'b0001 << addr_lo;
         HWORD:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
         WORD:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data is replicated across lanes so memory only needs the byte enables.
   function automatic logic [31:0] f_lsu_st_align(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] r;
      r = data;
      case (size)
         BYTE:    r = {4{data[7:0]}};
         HWORD:   r = {2{data[15:0]}};
         default: r = data;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] f_lsu_ld_extend(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                                   input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'h00;
      case (addr_lo)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         2'd3: b = word[31:24];
         default: b = word[7:0];
      endcase
      h = addr_lo[1] ? word[31:16] : word[15:0];
      r = word;
      case (funct3)
         F3_LB:   r = {{24{b[7]}}, b};
         F3_LBU:  r = {24'h000000, b};
         F3_LH:   r = {{16{h[15]}}, h};
         F3_LHU:  r = {16'h0000, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic f_lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == HWORD) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
   endfunction

   function automatic logic f_lsu_illegal(input logic is_load, input logic [2:0] funct3);
      if (is_load)
         return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      else
         return !(funct3 inside {F3_SB, F3_SH, F3_SW});
   endfunction

endpackage

// File: rtl/pqr5_lsu_if.sv
// rtl/pqr5_lsu_if.sv - data-memory port bundle between the LSU and memory
//
// Purpose: groups the data-memory request/response signals.
// Ports (signals):
//   dm_req_valid/dm_req_ready  request handshake
//   dm_addr, dm_we, dm_be, dm_wdata  request payload (word-aligned address)
//   dm_rsp_valid, dm_rdata  one-cycle load response
// Modports: master = LSU side, slave = memory side.

interface pqr5_lsu_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          dm_req_valid;
   logic          dm_req_ready;
   logic [AW-1:0] dm_addr;
   logic          dm_we;
   logic [3:0]    dm_be;
   logic [DW-1:0] dm_wdata;
   logic          dm_rsp_valid;
   logic [DW-1:0] dm_rdata;

   modport master (
      output dm_req_valid, dm_addr, dm_we, dm_be, dm_wdata,
      input  dm_req_ready, dm_rsp_valid, dm_rdata
   );

   modport slave (
      input  dm_req_valid, dm_addr, dm_we, dm_be, dm_wdata,
      output dm_req_ready, dm_rsp_valid, dm_rdata
   );
endinterface

// File: rtl/pqr5_lsu.sv
// rtl/pqr5_lsu.sv - PQR5 load/store unit, one transaction outstanding
//
// Purpose: captures a decoded LOAD/STORE from execute, issues an aligned
// 32-bit data-memory request with byte enables, and returns extended load
// data (or an exception for misaligned/illegal accesses) to writeback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid/ex_ready        execute handshake (ready only in IDLE)
//   ex_is_load, ex_funct3, ex_addr, ex_wdata, ex_rd   operation fields
//   dm                       data-memory port (pqr5_lsu_if.master)
//   wb_valid/wb_ready        writeback handshake
//   wb_rd, wb_data, wb_exc   writeback payload
//   st_done                  pulse when memory accepts a store

module pqr5_lsu #(
   parameter int RSIZE = pqr5_core_pkg::RSIZE,
   parameter int AW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic             ex_is_load,
   input  logic [2:0]       ex_funct3,
   input  logic [AW-1:0]    ex_addr,
   input  logic [RSIZE-1:0] ex_wdata,
   input  logic [4:0]       ex_rd,
   pqr5_lsu_if.master       dm,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [4:0]       wb_rd,
   output logic [RSIZE-1:0] wb_data,
   output logic             wb_exc,
   output logic             st_done
);
   import pqr5_core_pkg::*;

   lsu_state_e       state_q, state_d;
   logic             is_load_q;
   logic [2:0]       f3_q;
   logic [AW-1:0]    addr_q;
   logic [RSIZE-1:0] wdata_q;
   logic [4:0]       rd_q;
   logic [RSIZE-1:0] wb_data_q;
   logic             wb_exc_q;

   logic capture;
   logic cap_bad;

   assign capture = (state_q == LSU_IDLE) && ex_valid;
   assign cap_bad = f_lsu_illegal(ex_is_load, ex_funct3) ||
                    f_lsu_misaligned(ex_funct3[1:0], ex_addr[1:0]);

   always_ff @(posedge clk) begin
      if (rst) state_q <= LSU_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      ex_ready        = 1'b0;
      dm.dm_req_valid = 1'b0;
      dm.dm_addr      = '0;
      dm.dm_we        = 1'b0;
      dm.dm_be        = 4'b0000;
      dm.dm_wdata     = '0;
      wb_valid        = 1'b0;
      wb_rd           = 5'd0;
      wb_data         = '0;
      wb_exc          = 1'b0;
      st_done         = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            ex_ready = 1'b1;
            if (ex_valid) state_d = cap_bad ? LSU_WB : LSU_REQ;
         end
         LSU_REQ: begin
            // Driven purely from captured registers, so the request is stable while stalled.
            dm.dm_req_valid = 1'b1;
            dm.dm_addr      = {addr_q[AW-1:2], 2'b00};
            dm.dm_we        = !is_load_q;
            dm.dm_be        = f_lsu_be(f3_q[1:0], addr_q[1:0]);
            dm.dm_wdata     = is_load_q ? '0 : f_lsu_st_align(f3_q[1:0], wdata_q);
            if (dm.dm_req_ready) begin
               st_done = !is_load_q;
               state_d = is_load_q ? LSU_RSP : LSU_IDLE;
            end
         end
         LSU_RSP: begin
            if (dm.dm_rsp_valid) state_d = LSU_WB;
         end
         LSU_WB: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = wb_data_q;
            wb_exc   = wb_exc_q;
            if (wb_ready) state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_load_q <= 1'b0;
         f3_q      <= 3'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= 5'd0;
         wb_data_q <= '0;
         wb_exc_q  <= 1'b0;
      end else begin
         if (capture) begin
            is_load_q <= ex_is_load;
            f3_q      <= ex_funct3;
            addr_q    <= ex_addr;
            wdata_q   <= ex_wdata;
            rd_q      <= ex_rd;
            wb_data_q <= '0;
            wb_exc_q  <= cap_bad;
         end else if ((state_q == LSU_RSP) && dm.dm_rsp_valid) begin
            wb_data_q <= f_lsu_ld_extend(f3_q, addr_q[1:0], dm.dm_rdata);
         end
      end
   end

endmodule

// File: tb/tb_pqr5_lsu.sv
// tb/tb_pqr5_lsu.sv - scoreboard testbench for pqr5_lsu

module tb_pqr5_lsu;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exc;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_is_load;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic        wb_valid, wb_ready, wb_exc, st_done;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_pass   = 0;

   req_t req_q[$];
   wb_t  wb_q[$];

   pqr5_lsu_if #(.AW(32), .DW(32)) dm_if ();

   pqr5_lsu #(.RSIZE(32), .AW(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .dm(dm_if.master),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_exc(wb_exc), .st_done(st_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
      req_t r;
      r.addr = a; r.we = we; r.be = be; r.wdata = wd;
      req_q.push_back(r);
   endtask

   task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d, input logic exc);
      wb_t w;
      w.rd = rd; w.data = d; w.exc = exc;
      wb_q.push_back(w);
   endtask

   // Monitor: compares presented outputs with the head of the expectation queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (dm_if.dm_req_valid) begin
            chk("ex_ready_busy_req", {31'd0, ex_ready}, 32'd0);
            if (req_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
            end else begin
               chk("dm_addr",  dm_if.dm_addr, req_q[0].addr);
               chk("dm_we",    {31'd0, dm_if.dm_we}, {31'd0, req_q[0].we});
               chk("dm_be",    {28'd0, dm_if.dm_be}, {28'd0, req_q[0].be});
               chk("dm_wdata", dm_if.dm_wdata, req_q[0].wdata);
               if (dm_if.dm_req_ready) begin
                  chk("st_done", {31'd0, st_done}, {31'd0, req_q[0].we});
                  void'(req_q.pop_front());
               end
            end
         end else if (st_done) begin
            chk("st_done_spurious", 32'd1, 32'd0);
         end
         if (wb_valid) begin
            chk("ex_ready_busy_wb", {31'd0, ex_ready}, 32'd0);
            if (wb_q.size() == 0) begin
               chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
               chk("wb_rd",   {27'd0, wb_rd}, {27'd0, wb_q[0].rd});
               chk("wb_data", wb_data, wb_q[0].data);
               chk("wb_exc",  {31'd0, wb_exc}, {31'd0, wb_q[0].exc});
               if (wb_ready) void'(wb_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ex_ready();
      int n = 0;
      while (!ex_ready && n < 20) begin
         step();
         n++;
      end
      chk("ex_ready_wait", {31'd0, ex_ready}, 32'd1);
   endtask

   task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdata, input int req_wait,
                         input int rsp_wait, input int wb_wait, input logic exc);
      int n;
      wait_ex_ready();
      ex_valid = 1'b1; ex_is_load = ld; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
      step();
      ex_valid = 1'b0;
      if (!exc) begin
         repeat (req_wait) step();
         dm_if.dm_req_ready = 1'b1;
         step();
         dm_if.dm_req_ready = 1'b0;
         if (ld) begin
            repeat (rsp_wait) step();
            dm_if.dm_rdata = rdata;
            dm_if.dm_rsp_valid = 1'b1;
            chk("wb_before_rsp", {31'd0, wb_valid}, 32'd0);
            step();
            dm_if.dm_rsp_valid = 1'b0;
            dm_if.dm_rdata = 32'h0;
            chk("wb_one_after_rsp", {31'd0, wb_valid}, 32'd1);
         end
      end
      if (ld || exc) begin
         n = 0;
         while (!wb_valid && n < 20) begin
            step();
            n++;
         end
         chk("wb_valid_wait", {31'd0, wb_valid}, 32'd1);
         repeat (wb_wait) step();
         wb_ready = 1'b1;
         step();
         wb_ready = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_funct3 = 3'd0; ex_addr = 32'd0;
      ex_wdata = 32'd0; ex_rd = 5'd0; wb_ready = 1'b0;
      dm_if.dm_req_ready = 1'b0; dm_if.dm_rsp_valid = 1'b0; dm_if.dm_rdata = 32'd0;
      step(); step();
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_req_valid", {31'd0, dm_if.dm_req_valid}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_be", {28'd0, dm_if.dm_be}, 32'd0);
      rst = 1'b0;
      step();

      // SB 0x1003
      exp_req(32'h1000, 1'b1, 4'b1000, 32'hA5A5A5A5);
      run_op(1'b0, 3'b000, 32'h1003, 32'h000000A5, 5'd0, 32'h0, 0, 0, 0, 1'b0);
      // LH / LHU 0x2002
      exp_req(32'h2000, 1'b0, 4'b1100, 32'h0);
      exp_wb(5'd5, 32'hFFFF8001, 1'b0);
      run_op(1'b1, 3'b001, 32'h2002, 32'h0, 5'd5, 32'h80011234, 0, 0, 0, 1'b0);
      exp_req(32'h2000, 1'b0, 4'b1100, 32'h0);
      exp_wb(5'd6, 32'h00008001, 1'b0);
      run_op(1'b1, 3'b101, 32'h2002, 32'h0, 5'd6, 32'h80011234, 0, 0, 0, 1'b0);
      // LB 0x11, response delayed 5 cycles
      exp_req(32'h10, 1'b0, 4'b0010, 32'h0);
      exp_wb(5'd7, 32'h0000007F, 1'b0);
      run_op(1'b1, 3'b000, 32'h11, 32'h0, 5'd7, 32'h00007F00, 0, 5, 0, 1'b0);
      // Misaligned LW / SH
      exp_wb(5'd8, 32'h0, 1'b1);
      run_op(1'b1, 3'b010, 32'h06, 32'h0, 5'd8, 32'h0, 0, 0, 0, 1'b1);
      exp_wb(5'd9, 32'h0, 1'b1);
      run_op(1'b0, 3'b001, 32'h01, 32'h1234, 5'd9, 32'h0, 0, 0, 0, 1'b1);
      // SW with memory stall of 4 cycles
      exp_req(32'h40, 1'b1, 4'b1111, 32'h12345678);
      run_op(1'b0, 3'b010, 32'h40, 32'h12345678, 5'd0, 32'h0, 4, 0, 0, 1'b0);
      // LW with memory stall and writeback stall
      exp_req(32'h100, 1'b0, 4'b1111, 32'h0);
      exp_wb(5'd10, 32'hDEADBEEF, 1'b0);
      run_op(1'b1, 3'b010, 32'h100, 32'h0, 5'd10, 32'hDEADBEEF, 4, 2, 3, 1'b0);
      // SH upper half
      exp_req(32'h20, 1'b1, 4'b1100, 32'h12341234);
      run_op(1'b0, 3'b001, 32'h22, 32'hABCD1234, 5'd0, 32'h0, 0, 0, 0, 1'b0);
      // LB top lane, negative
      exp_req(32'h30, 1'b0, 4'b1000, 32'h0);
      exp_wb(5'd11, 32'hFFFFFF80, 1'b0);
      run_op(1'b1, 3'b000, 32'h33, 32'h0, 5'd11, 32'h80000000, 0, 1, 0, 1'b0);
      // Illegal funct3 load and store
      exp_wb(5'd12, 32'h0, 1'b1);
      run_op(1'b1, 3'b011, 32'h0, 32'h0, 5'd12, 32'h0, 0, 0, 0, 1'b1);
      exp_wb(5'd13, 32'h0, 1'b1);
      run_op(1'b0, 3'b100, 32'h0, 32'h0, 5'd13, 32'h0, 0, 0, 0, 1'b1);

      // Reset while waiting for a load response
      wait_ex_ready();
      exp_req(32'h0, 1'b0, 4'b0001, 32'h0);
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b100; ex_addr = 32'h0; ex_rd = 5'd14;
      step();
      ex_valid = 1'b0;
      dm_if.dm_req_ready = 1'b1;
      step();
      dm_if.dm_req_ready = 1'b0;
      rst = 1'b1;
      step();
      chk("rst_mid_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_mid_req_valid", {31'd0, dm_if.dm_req_valid}, 32'd0);
      chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_mid_wb_data", wb_data, 32'd0);
      chk("rst_mid_st_done", {31'd0, st_done}, 32'd0);
      rst = 1'b0;
      dm_if.dm_rdata = 32'h000000FF;
      dm_if.dm_rsp_valid = 1'b1;
      step();
      dm_if.dm_rsp_valid = 1'b0;
      repeat (3) begin
         chk("late_rsp_no_wb", {31'd0, wb_valid}, 32'd0);
         step();
      end

      chk("req_q_drained", req_q.size(), 32'd0);
      chk("wb_q_drained", wb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
